// File: rtl/iic_target_regs.sv
// I2C target with an 8-entry ADT7420-style register map. SCL/SDA are oversampled on
// CLK_100, synchronised, glitch-filtered and decoded by a single bus FSM.
module iic_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h4B,
  parameter int unsigned FILT     = 3
) (
  input  logic        CLK_100,
  input  logic        RSTn,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] Temp_in,
  output logic [7:0]  Cfg_out,
  output logic        Wr_Strobe,
  output logic [2:0]  Wr_Addr,
  output logic [7:0]  Wr_Data,
  output logic        Busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_ACKCHK,
    WAIT_STOP
  } state_t;

  // Index 1 carries SCL, index 0 carries SDA through the same sync + filter path.
  logic [1:0] pin_raw;
  logic [1:0] pin_filt;

  assign pin_raw = {SCL, SDA};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      logic [1:0]       sync_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             filt_reg;

      always_ff @(posedge CLK_100) begin
        if (!RSTn) begin
          sync_reg <= 2'b11;
          cnt_reg  <= '0;
          filt_reg <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[0], pin_raw[gi]};
          if (sync_reg[1] == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(FILT - 1)) begin
            filt_reg <= sync_reg[1];
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign pin_filt[gi] = filt_reg;
    end
  endgenerate

  logic scl_f;
  logic sda_f;
  logic scl_q_reg;
  logic sda_q_reg;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_f     = pin_filt[1];
  assign sda_f     = pin_filt[0];
  assign scl_rise  = scl_f & ~scl_q_reg;
  assign scl_fall  = ~scl_f & scl_q_reg;
  // SCL must be high on both samples so an SDA change at an SCL edge is not a condition.
  assign start_det = scl_f & scl_q_reg & sda_q_reg & ~sda_f;
  assign stop_det  = scl_f & scl_q_reg & ~sda_q_reg & sda_f;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  ptr_reg, ptr_next;
  logic        rw_reg, rw_next;
  logic        mack_reg, mack_next;
  logic        sda_oe_reg, sda_oe_next;
  logic [15:0] snap_reg, snap_next;
  logic        wr_en;
  logic        wr_strobe_next;
  logic [7:0]  wr_data;
  logic [7:0]  rd_byte;
  logic [7:0]  reg_q [8];

  assign reg_q[0] = snap_reg[15:8];
  assign reg_q[1] = snap_reg[7:0];
  assign reg_q[2] = 8'h00;

  generate
    for (gi = 3; gi < 8; gi++) begin : g_reg
      logic [7:0] data_reg;

      always_ff @(posedge CLK_100) begin
        if (!RSTn) begin
          data_reg <= 8'h00;
        end else if (wr_en && (ptr_reg == 3'(gi))) begin
          data_reg <= wr_data;
        end
      end

      assign reg_q[gi] = data_reg;
    end
  endgenerate

  assign rd_byte        = reg_q[ptr_reg];
  assign wr_data        = {shift_reg[6:0], sda_f};
  assign wr_strobe_next = wr_en && (ptr_reg >= 3'd3);
  assign Cfg_out        = reg_q[3];
  assign Busy           = (state_reg != IDLE);
  assign SDA            = sda_oe_reg ? 1'b0 : 1'bz;

  always_ff @(posedge CLK_100) begin
    if (!RSTn) begin
      scl_q_reg   <= 1'b1;
      sda_q_reg   <= 1'b1;
      state_reg   <= IDLE;
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'h00;
      ptr_reg     <= 3'd0;
      rw_reg      <= 1'b0;
      mack_reg    <= 1'b0;
      sda_oe_reg  <= 1'b0;
      snap_reg    <= 16'h0000;
      Wr_Strobe   <= 1'b0;
      Wr_Addr     <= 3'd0;
      Wr_Data     <= 8'h00;
    end else begin
      scl_q_reg   <= scl_f;
      sda_q_reg   <= sda_f;
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      ptr_reg     <= ptr_next;
      rw_reg      <= rw_next;
      mack_reg    <= mack_next;
      sda_oe_reg  <= sda_oe_next;
      snap_reg    <= snap_next;
      Wr_Strobe   <= wr_strobe_next;
      if (wr_strobe_next) begin
        Wr_Addr <= ptr_reg;
        Wr_Data <= wr_data;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    ptr_next     = ptr_reg;
    rw_next      = rw_reg;
    mack_next    = mack_reg;
    sda_oe_next  = sda_oe_reg;
    snap_next    = snap_reg;
    wr_en        = 1'b0;

    // Bus conditions override any SCL edge seen in the same cycle.
    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
    end else if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE, WAIT_STOP: begin
          sda_oe_next = 1'b0;
        end

        ADDR, PTR: begin
          if (scl_rise && (bit_cnt_reg < 4'd8)) begin
            shift_next   = {shift_reg[6:0], sda_f};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && (bit_cnt_reg == 4'd8)) begin
            bit_cnt_next = 4'd0;
            if (state_reg == PTR) begin
              ptr_next    = shift_reg[2:0];
              sda_oe_next = 1'b1;
              state_next  = PTR_ACK;
            end else if (shift_reg[7:1] == DEV_ADDR) begin
              rw_next     = shift_reg[0];
              sda_oe_next = 1'b1;
              state_next  = ADDR_ACK;
              if (shift_reg[0]) begin
                snap_next = Temp_in;
              end
            end else begin
              state_next = WAIT_STOP;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_next = 4'd0;
            if (rw_reg) begin
              shift_next  = rd_byte;
              sda_oe_next = ~rd_byte[7];
              state_next  = RDATA;
            end else begin
              sda_oe_next = 1'b0;
              state_next  = PTR;
            end
          end
        end

        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 4'd0;
            state_next   = WDATA;
          end
        end

        WDATA: begin
          if (scl_rise && (bit_cnt_reg < 4'd8)) begin
            shift_next   = {shift_reg[6:0], sda_f};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            wr_en        = (bit_cnt_reg == 4'd7);
          end else if (scl_fall && (bit_cnt_reg == 4'd8)) begin
            sda_oe_next = 1'b1;
            ptr_next    = ptr_reg + 3'd1;
            state_next  = WDATA_ACK;
          end
        end

        RDATA: begin
          if (scl_rise && (bit_cnt_reg < 4'd8)) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_next = 1'b0;
              ptr_next    = ptr_reg + 3'd1;
              mack_next   = 1'b0;
              state_next  = RD_ACKCHK;
            end else begin
              shift_next  = {shift_reg[6:0], 1'b0};
              sda_oe_next = ~shift_reg[6];
            end
          end
        end

        RD_ACKCHK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_next = WAIT_STOP;
            end else begin
              mack_next = 1'b1;
            end
          end else if (scl_fall && mack_reg) begin
            shift_next   = rd_byte;
            sda_oe_next  = ~rd_byte[7];
            bit_cnt_next = 4'd0;
            state_next   = RDATA;
          end
        end

        default: begin
          sda_oe_next = 1'b0;
          state_next  = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_target_regs.sv
// Bit-banged I2C master driving iic_target_regs, checked against a register-map model
// (pointer, snapshot, write strobes) with directed and randomized transactions.
module tb_iic_target_regs;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic        scl;
  logic        m_sda_low;
  logic [15:0] temp_in;
  logic [7:0]  cfg_out;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  wire         sda_bus;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  iic_target_regs #(
    .DEV_ADDR (7'h4B),
    .FILT     (3)
  ) dut (
    .CLK_100   (clk),
    .RSTn      (rstn),
    .SCL       (scl),
    .SDA       (sda_bus),
    .Temp_in   (temp_in),
    .Cfg_out   (cfg_out),
    .Wr_Strobe (wr_strobe),
    .Wr_Addr   (wr_addr),
    .Wr_Data   (wr_data),
    .Busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the register map
  logic [7:0]  mregs [8];
  logic [2:0]  mptr;
  logic [15:0] msnap;
  logic [10:0] exp_q [$];
  logic [10:0] got_q [$];
  logic [7:0]  wbuf [8];

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) got_q.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sda_line();
    return (sda_bus === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic m_write(input logic [7:0] d);
    if (mptr >= 3) begin
      mregs[mptr] = d;
      exp_q.push_back({mptr, d});
    end
    mptr = 3'((int'(mptr) + 1) % 8);
  endtask

  task automatic m_read(output logic [7:0] d);
    case (mptr)
      3'd0:    d = msnap[15:8];
      3'd1:    d = msnap[7:0];
      3'd2:    d = 8'h00;
      default: d = mregs[mptr];
    endcase
    mptr = 3'((int'(mptr) + 1) % 8);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; cyc(Q);
    scl = 1'b1;       cyc(Q);
    m_sda_low = 1'b1; cyc(Q);
    scl = 1'b0;       cyc(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; cyc(Q);
    scl = 1'b1;       cyc(Q);
    m_sda_low = 1'b0; cyc(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; cyc(Q);
    scl = 1'b1;     cyc(2 * Q);
    scl = 1'b0;     cyc(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; cyc(Q);
    scl = 1'b1;       cyc(Q);
    b = sda_line();   cyc(Q);
    scl = 1'b0;       cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic mack);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
    write_bit(~mack);
  endtask

  task automatic chk_strobes();
    chk("strobe_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("strobe_addr_data", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wr_txn(input logic [2:0] p, input int n);
    logic ack;
    logic [4:0] up;
    up = 5'($urandom);
    $display("txn write ptr=%0d bytes=%0d upper=%0h", p, n, up);
    bus_start();
    chk("busy_after_start", busy, 1);
    send_byte(8'h96, ack);
    chk("wr_addr_ack", ack, 1);
    send_byte({up, p}, ack);
    chk("wr_ptr_ack", ack, 1);
    mptr = p;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      chk("wr_data_ack", ack, 1);
      m_write(wbuf[i]);
    end
    bus_stop();
    chk("busy_after_stop", busy, 0);
    chk_strobes();
    chk("cfg_out", cfg_out, mregs[3]);
  endtask

  task automatic rd_txn(input logic [2:0] p, input int n, input int chg_idx,
                        input logic [15:0] chg_val);
    logic ack;
    logic [7:0] got;
    logic [7:0] exp;
    $display("txn read ptr=%0d bytes=%0d temp=%04h", p, n, temp_in);
    bus_start();
    send_byte(8'h96, ack);
    chk("rd_waddr_ack", ack, 1);
    send_byte({5'b00000, p}, ack);
    chk("rd_ptr_ack", ack, 1);
    mptr = p;
    bus_start();
    send_byte(8'h97, ack);
    chk("rd_raddr_ack", ack, 1);
    msnap = temp_in;
    for (int i = 0; i < n; i++) begin
      if (i == chg_idx) temp_in = chg_val;
      recv_byte(got, i < n - 1);
      m_read(exp);
      chk("rd_data", got, exp);
    end
    bus_stop();
    chk("rd_busy_after_stop", busy, 0);
    chk("rd_no_strobe", got_q.size(), 0);
  endtask

  initial begin : main
    logic ack;
    logic busy_seen;
    int   n;

    rstn = 1'b0; scl = 1'b1; m_sda_low = 1'b0; temp_in = 16'h0C80;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    mptr = 3'd0; msnap = 16'h0000;
    cyc(5);
    rstn = 1'b1;
    cyc(2);
    $display("txn reset");
    chk("rst_sda", sda_line(), 1);
    chk("rst_busy", busy, 0);
    chk("rst_cfg", cfg_out, 8'h00);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_waddr", wr_addr, 0);
    chk("rst_wdata", wr_data, 8'h00);

    // Config write
    wbuf[0] = 8'hA5;
    wr_txn(3'd3, 1);
    chk("cfg_a5", cfg_out, 8'hA5);

    // Temperature read with repeated START; Temp_in changes mid-read
    temp_in = 16'h0C80;
    rd_txn(3'd0, 2, 0, 16'h0D00);

    // Wrong address: no ACKs, no writes
    $display("txn wrong address 0xA0");
    bus_start();
    send_byte(8'hA0, ack);
    chk("bad_addr_nack", ack, 0);
    send_byte(8'h03, ack);
    chk("bad_ptr_nack", ack, 0);
    send_byte(8'h77, ack);
    chk("bad_data_nack", ack, 0);
    bus_stop();
    chk("bad_busy", busy, 0);
    chk_strobes();
    chk("bad_cfg", cfg_out, mregs[3]);

    // Auto-increment wrap from 0x06
    temp_in = 16'h1E40;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    wr_txn(3'd6, 3);
    rd_txn(3'd6, 3, -1, 16'h0000);

    // Randomized traffic
    for (int t = 0; t < 8; t++) begin
      temp_in = 16'($urandom);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        wr_txn(3'($urandom_range(0, 7)), n);
      end else begin
        rd_txn(3'($urandom_range(0, 7)), n, -1, 16'h0000);
      end
    end

    // STOP after 4 bits of a data byte
    wbuf[0] = 8'h5A;
    wr_txn(3'd3, 1);
    $display("txn abort mid-byte");
    bus_start();
    send_byte(8'h96, ack);
    send_byte(8'h04, ack);
    mptr = 3'd4;
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    bus_stop();
    chk("abort_busy", busy, 0);
    chk("abort_sda", sda_line(), 1);
    chk_strobes();
    rd_txn(3'd4, 1, -1, 16'h0000);

    // Reset while the target is driving an address ACK
    $display("txn reset during ack");
    chk("pre_rst_cfg", cfg_out, 8'h5A);
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(((8'h96 >> i) & 8'h01) != 0);
    m_sda_low = 1'b0; cyc(Q);
    scl = 1'b1;       cyc(Q);
    chk("ack_driven", sda_line(), 0);
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    chk("rst_ack_sda", sda_line(), 1);
    chk("rst_ack_cfg", cfg_out, 8'h00);
    chk("rst_ack_busy", busy, 0);
    for (int i = 3; i < 8; i++) mregs[i] = 8'h00;
    cyc(Q);
    scl = 1'b0; cyc(Q);
    bus_stop();
    chk("post_rst_busy", busy, 0);

    // Glitch filter: a 2-cycle SDA dip is ignored, a 5-cycle dip is a START then STOP
    $display("txn glitch 2-cycle");
    busy_seen = 1'b0;
    m_sda_low = 1'b1; cyc(2);
    m_sda_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      busy_seen = busy_seen | busy;
    end
    chk("glitch_ignored", busy_seen, 0);
    $display("txn glitch 5-cycle");
    busy_seen = 1'b0;
    m_sda_low = 1'b1; cyc(5);
    m_sda_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      busy_seen = busy_seen | busy;
    end
    chk("long_dip_start", busy_seen, 1);
    chk("long_dip_stop", busy, 0);
    chk_strobes();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iic_target_regs.md
Name: iic_target_regs

Overview:
- I2C target (slave) with a small register file, modelled on the ADT7420 register map.
- Answers the team's I2C master: write-pointer, write-data and read transfers, including repeated START.
- Used in loopback and bring-up, and as an on-FPGA sensor emulator feeding Temp_in to the master.
- Samples SCL/SDA on CLK_100; no clock stretching.

Parameters:
- DEV_ADDR, 7'h4B, 7-bit target address matched after START
- FILT, 3, CLK_100 cycles SCL/SDA must hold stable before a filtered level change is accepted (1..15)

Ports:
- CLK_100  in  1  system clock, 100 MHz
- RSTn  in  1  reset, synchronous, active-low
- SCL  in  1  I2C clock from master
- SDA  inout  1  open-drain data; block drives 0 or Z, never 1
- Temp_in  in  16  live temperature word; [15:8] is reg 0x00, [7:0] is reg 0x01
- Cfg_out  out  8  contents of reg 0x03
- Wr_Strobe  out  1  one-cycle pulse per accepted data-byte write
- Wr_Addr  out  3  register written (valid with Wr_Strobe)
- Wr_Data  out  8  byte written (valid with Wr_Strobe)
- Busy  out  1  high from START to STOP

Behaviour:
- Reset (RSTn=0 at CLK_100 edge):
  - SDA released (Z); FSM to IDLE; pointer=0.
  - Regs 0x02..0x07 = 8'h00; Cfg_out=0; Wr_Strobe=0; Wr_Addr=0; Wr_Data=0; Busy=0.
  - Reset mid-transfer aborts immediately; the bus sees a NACK or released line.
- Input path:
  - 2-FF synchronizer on SCL and SDA, then FILT-cycle stability filter.
  - Edge detects are taken on the filtered signals.
  - Latency from pin to decision is at most FILT+3 cycles.
- Conditions:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are recognised in any state, including mid-byte.
  - START (incl. repeated) goes to ADDR with Busy=1 and bit count cleared.
  - STOP goes to IDLE with Busy=0 and SDA released.
- Bit timing:
  - Incoming bits are sampled on the filtered SCL rising edge, MSB first.
  - The block changes SDA only on the cycle after a filtered SCL falling edge.
- Register map (8 entries, 3-bit pointer):
  - 0x00/0x01: read-only, from a snapshot of Temp_in.
  - 0x02: read-only status, returns 8'h00.
  - 0x03..0x07: read/write.
  - Writes to 0x00..0x02 are ACKed and discarded, with no Wr_Strobe.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACKCHK, WAIT_STOP.
  - IDLE: SDA Z; waits for START.
  - ADDR: shifts 8 bits (7 address + R/W).
    - On address match: ACK (drive 0) from the falling edge after bit 8 until the next falling edge. R/W=0 goes to PTR; R/W=1 goes to RDATA.
    - On mismatch: no ACK, go to WAIT_STOP.
  - Read entry: Temp_in is captured into the snapshot at the ADDR_ACK entry of every read, so MSB/LSB read back coherently.
  - PTR: 8 bits received; pointer = byte[2:0], upper bits ignored; ACK; then WDATA.
  - WDATA: each byte is written to reg[pointer] at the SCL rising edge of bit 8.
    - Wr_Strobe pulses in that cycle, with Wr_Addr = pointer.
    - ACK follows; pointer increments modulo 8 (0x07 wraps to 0x00).
  - RDATA: reg[pointer] is loaded to the shifter at the falling edge ending the ACK.
    - 8 bits driven (0 = drive low, 1 = Z).
    - SDA released for the 9th bit; pointer increments modulo 8.
  - RD_ACKCHK: samples master ACK on the 9th rising edge.
    - ACK (0): next byte in RDATA.
    - NACK (1): WAIT_STOP.
  - WAIT_STOP: SDA Z; leaves only on STOP or START.
- Simultaneity:
  - A START/STOP detected in the same cycle as an SCL edge takes priority; the bit is discarded.
  - A partial byte is never written.
- Cfg_out is combinationally equal to reg 0x03.
- SDA never driven 1; SCL never driven.

Test Plan:
- Write config: START, 0x96 (0x4B<<1|0), 0x03, 0xA5, STOP -> three ACKs; Wr_Strobe once with Wr_Addr=3, Wr_Data=0xA5; Cfg_out=0xA5; Busy falls after STOP.
- Temperature read with repeated START: Temp_in=16'h0C80; START, 0x96, 0x00, Sr, 0x97, read 2 bytes (ACK, NACK), STOP -> master receives 0x0C then 0x80.
  - Changing Temp_in to 16'h0D00 between the two bytes still yields 0x80 (snapshot).
- Wrong address: START, 0xA0 -> SDA stays Z at 9th clock (NACK); the following bytes get no ACKs and no Wr_Strobe; STOP returns to IDLE.
- Auto-increment wrap: write 0x11,0x22,0x33 starting at pointer 0x06 -> regs 6=0x11, 7=0x22, then the third write targets reg 0x00 (no strobe; reg 0 still reads Temp_in snapshot).
  - Read-back from 0x06 for 3 bytes returns 0x11, 0x22, Temp_in[15:8].
- Aborts: STOP after 4 bits of a data byte -> no write, IDLE, SDA Z; then RSTn=0 for one CLK_100 cycle while driving an ACK -> SDA Z next cycle, Cfg_out=0x00, Busy=0.
- Glitch filter: FILT=3; 2-cycle low pulse on SDA while SCL high -> no START detected, Busy stays 0.
